// File: rtl/aes3_frame_transmitter_if.sv
// Sample source to transmitter handshake: one stereo sample with its V and U bits.
// The master is the audio source; the slave is the transmitter's input buffer.
interface aes3_frame_transmitter_if #(
  parameter int SAMPLE_WIDTH = 24
);
  logic [2*SAMPLE_WIDTH-1:0] sample_i;
  logic                      sample_valid_i;
  logic                      sample_ready_o;
  logic [1:0]                valid_i;
  logic [1:0]                user_i;

  modport master (
    output sample_i, sample_valid_i, valid_i, user_i,
    input  sample_ready_o
  );

  modport slave (
    input  sample_i, sample_valid_i, valid_i, user_i,
    output sample_ready_o
  );
endinterface

// File: rtl/aes3_frame_transmitter.sv
// AES3/S/PDIF biphase-mark transmitter: one-entry sample buffer, UI prescaler,
// 128-UI frame sequencer, 192-frame channel-status block with Z preamble at frame 0.
module aes3_frame_transmitter #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int UI_DIV       = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           halt,
  aes3_frame_transmitter_if.slave        smp,
  input  logic [191:0]                   cs_i,
  output logic                           tx_o,
  output logic                           underrun_o,
  output logic                           block_start_o
);

  localparam int PW = (UI_DIV > 1) ? $clog2(UI_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(UI_DIV - 1);

  localparam logic [7:0] PRE_Z = 8'b11101000;
  localparam logic [7:0] PRE_X = 8'b11100010;
  localparam logic [7:0] PRE_Y = 8'b11100100;

  logic [PW-1:0]               presc_q, presc_d;
  logic [6:0]                  ui_cnt_q, ui_cnt_d;
  logic [7:0]                  frame_cnt_q, frame_cnt_d;
  logic                        tx_q, tx_d;
  logic                        inv_q, inv_d;
  logic [191:0]                cs_q, cs_d;

  logic                        buf_full_q, buf_full_d;
  logic [2*SAMPLE_WIDTH-1:0]   buf_sample_q, buf_sample_d;
  logic [1:0]                  buf_v_q, buf_v_d;
  logic [1:0]                  buf_u_q, buf_u_d;

  logic [1:0][23:0]            frm_aud_q, frm_aud_d;
  logic [1:0]                  frm_v_q, frm_v_d;
  logic [1:0]                  frm_u_q, frm_u_d;

  logic                        tick;
  logic                        load;
  logic                        block_start;
  logic                        xfer;
  logic                        sub_b;
  logic [5:0]                  pos;
  logic [7:0]                  pre;
  logic                        cbit;
  logic                        par;
  logic [31:0]                 slots;
  logic [23:0]                 buf_al [2];

  assign tick        = !halt && (presc_q == PRESC_MAX);
  assign load        = tick && (ui_cnt_q == 7'd7);
  assign block_start = tick && (ui_cnt_q == 7'd0) && (frame_cnt_q == 8'd0);

  assign smp.sample_ready_o = rst_n && !buf_full_q;
  assign xfer               = smp.sample_valid_i && smp.sample_ready_o;

  assign tx_o          = tx_q;
  assign underrun_o    = rst_n && load && !buf_full_q;
  assign block_start_o = rst_n && block_start;

  // Buffered samples are MSB-aligned to slot 27 so narrow widths leave the low slots at 0.
  for (genvar gi = 0; gi < 2; gi++) begin : g_align
    assign buf_al[gi] = 24'(buf_sample_q[gi*SAMPLE_WIDTH +: SAMPLE_WIDTH]) << (24 - SAMPLE_WIDTH);
  end

  assign sub_b = ui_cnt_q[6];
  assign pos   = ui_cnt_q[5:0];
  assign pre   = sub_b ? PRE_Y : ((frame_cnt_q == 8'd0) ? PRE_Z : PRE_X);
  assign cbit  = cs_q[frame_cnt_q];
  assign par   = ^{cbit, frm_u_q[sub_b], frm_v_q[sub_b], frm_aud_q[sub_b]};
  // Indexed by slot number: bits 3:0 are the preamble slots and never read.
  assign slots = {par, cbit, frm_u_q[sub_b], frm_v_q[sub_b], frm_aud_q[sub_b], 4'b0000};

  always_comb begin
    presc_d      = presc_q;
    ui_cnt_d     = ui_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    tx_d         = tx_q;
    inv_d        = inv_q;
    cs_d         = cs_q;
    buf_full_d   = buf_full_q;
    buf_sample_d = buf_sample_q;
    buf_v_d      = buf_v_q;
    buf_u_d      = buf_u_q;
    frm_aud_d    = frm_aud_q;
    frm_v_d      = frm_v_q;
    frm_u_d      = frm_u_q;

    if (!halt) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end

    if (tick) begin
      ui_cnt_d = ui_cnt_q + 7'd1;
      if (ui_cnt_q == 7'd127) begin
        frame_cnt_d = (frame_cnt_q == 8'd191) ? 8'd0 : frame_cnt_q + 8'd1;
      end
      if (block_start) begin
        cs_d = cs_i;
      end

      // Preamble polarity follows the line level left by the previous subframe.
      if (pos < 6'd8) begin
        if (pos == 6'd0) begin
          inv_d = tx_q;
          tx_d  = pre[7] ^ tx_q;
        end else begin
          tx_d  = pre[~pos[2:0]] ^ inv_q;
        end
      end else if (!pos[0]) begin
        tx_d = ~tx_q;
      end else begin
        tx_d = tx_q ^ slots[pos[5:1]];
      end
    end

    if (load) begin
      if (buf_full_q) begin
        frm_aud_d[0] = buf_al[0];
        frm_aud_d[1] = buf_al[1];
        frm_v_d      = buf_v_q;
        frm_u_d      = buf_u_q;
        buf_full_d   = 1'b0;
      end else begin
        frm_aud_d = '0;
        frm_v_d   = 2'b11;
        frm_u_d   = 2'b00;
      end
    end

    // Only possible while the buffer is empty, so it never collides with the load above.
    if (xfer) begin
      buf_sample_d = smp.sample_i;
      buf_v_d      = smp.valid_i;
      buf_u_d      = smp.user_i;
      buf_full_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q      <= '0;
      ui_cnt_q     <= '0;
      frame_cnt_q  <= '0;
      tx_q         <= 1'b0;
      inv_q        <= 1'b0;
      cs_q         <= '0;
      buf_full_q   <= 1'b0;
      buf_sample_q <= '0;
      buf_v_q      <= '0;
      buf_u_q      <= '0;
      frm_aud_q    <= '0;
      frm_v_q      <= '0;
      frm_u_q      <= '0;
    end else begin
      presc_q      <= presc_d;
      ui_cnt_q     <= ui_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      tx_q         <= tx_d;
      inv_q        <= inv_d;
      cs_q         <= cs_d;
      buf_full_q   <= buf_full_d;
      buf_sample_q <= buf_sample_d;
      buf_v_q      <= buf_v_d;
      buf_u_q      <= buf_u_d;
      frm_aud_q    <= frm_aud_d;
      frm_v_q      <= frm_v_d;
      frm_u_q      <= frm_u_d;
    end
  end

endmodule

// File: tb/tb_aes3_frame_transmitter.sv
// Scoreboard bench: stimulus pushes the expected per-UI line level and pulses of each
// frame; a negedge monitor per instance pops one entry per UI tick and compares.
`timescale 1ns/1ps
module tb_aes3_frame_transmitter;

  localparam int SW0 = 24, DIV0 = 1;
  localparam int SW1 = 16, DIV1 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n0, rst_n1, halt0, halt1;
  logic [191:0] cs0, cs1;
  logic         tx0, tx1, ur0, ur1, bs0, bs1;

  aes3_frame_transmitter_if #(.SAMPLE_WIDTH(SW0)) if0 ();
  aes3_frame_transmitter_if #(.SAMPLE_WIDTH(SW1)) if1 ();

  aes3_frame_transmitter #(.SAMPLE_WIDTH(SW0), .UI_DIV(DIV0)) dut0 (
    .clk(clk), .rst_n(rst_n0), .halt(halt0), .smp(if0), .cs_i(cs0),
    .tx_o(tx0), .underrun_o(ur0), .block_start_o(bs0)
  );

  aes3_frame_transmitter #(.SAMPLE_WIDTH(SW1), .UI_DIV(DIV1)) dut1 (
    .clk(clk), .rst_n(rst_n1), .halt(halt1), .smp(if1), .cs_i(cs1),
    .tx_o(tx1), .underrun_o(ur1), .block_start_o(bs1)
  );

  typedef struct packed {
    logic tx;
    logic bs;
    logic ur;
  } ent_t;

  ent_t q0[$];
  ent_t q1[$];

  int   n_vec  = 0;
  int   n_fail = 0;

  // Model and monitor state, indexed by instance.
  logic lvl_m [2];
  int   frm_m [2];
  int   pops [2];
  int   presc [2];
  logic prev_rst [2];
  logic have_exp [2];
  logic just_popped [2];
  logic cur_tx [2];
  int   cur_idx [2];
  logic cap [2][256];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: actual=%0h required=%0h", name, idx, act, exp);
    end
  endtask

  task automatic push_ent(input int id, input ent_t e);
    if (id == 0) q0.push_back(e);
    else         q1.push_back(e);
  endtask

  // Encode both subframes of one frame into per-UI expectations.
  task automatic push_frame(input int id, input bit has, input logic [23:0] a_al, input logic [23:0] b_al,
                            input logic [1:0] v, input logic [1:0] u, input logic c, input int f);
    logic       lvl, inv;
    logic [7:0] pre;
    logic [27:0] sl;
    ent_t       e;
    lvl = lvl_m[id];
    for (int sub = 0; sub < 2; sub++) begin
      pre = (sub == 1) ? 8'b11100100 : ((f == 0) ? 8'b11101000 : 8'b11100010);
      inv = lvl;
      for (int k = 0; k < 8; k++) begin
        e.tx = pre[7-k] ^ inv;
        e.bs = (sub == 0 && k == 0 && f == 0);
        e.ur = (sub == 0 && k == 7 && !has);
        push_ent(id, e);
        lvl = e.tx;
      end
      sl[26:0] = {c, u[sub], v[sub], (sub == 1) ? b_al : a_al};
      sl[27]   = ^sl[26:0];
      for (int j = 0; j < 28; j++) begin
        e.bs = 1'b0;
        e.ur = 1'b0;
        lvl  = ~lvl;
        e.tx = lvl;
        push_ent(id, e);
        lvl  = lvl ^ sl[j];
        e.tx = lvl;
        push_ent(id, e);
      end
    end
    lvl_m[id] = lvl;
  endtask

  task automatic mon_step(input int id, input logic tx, input logic bs, input logic ur,
                          input logic rstn, input logic hlt, input int div);
    ent_t e;
    logic tick_now;
    int   qsz;
    if (prev_rst[id]) begin
      chk($sformatf("dut%0d reset_tx", id), 0, {31'd0, tx}, 32'd0);
      have_exp[id] = 1'b0;
    end else if (have_exp[id]) begin
      chk($sformatf("dut%0d tx_level", id), cur_idx[id], {31'd0, tx}, {31'd0, cur_tx[id]});
      if (just_popped[id] && cur_idx[id] < 256) cap[id][cur_idx[id]] = tx;
    end
    just_popped[id] = 1'b0;

    tick_now = rstn && !hlt && (presc[id] == div - 1);
    qsz = (id == 0) ? q0.size() : q1.size();
    if (tick_now) begin
      if (qsz == 0) begin
        have_exp[id] = 1'b0;
      end else begin
        e = (id == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("dut%0d block_start", id), pops[id], {31'd0, bs}, {31'd0, e.bs});
        chk($sformatf("dut%0d underrun", id), pops[id], {31'd0, ur}, {31'd0, e.ur});
        cur_tx[id]      = e.tx;
        cur_idx[id]     = pops[id];
        have_exp[id]    = 1'b1;
        just_popped[id] = 1'b1;
        pops[id]        = pops[id] + 1;
      end
    end else begin
      chk($sformatf("dut%0d idle_pulses", id), pops[id], {30'd0, bs, ur}, 32'd0);
    end

    prev_rst[id] = !rstn;
    if (!rstn)     presc[id] = 0;
    else if (!hlt) presc[id] = (presc[id] == div - 1) ? 0 : presc[id] + 1;
  endtask

  always @(negedge clk) mon_step(0, tx0, bs0, ur0, rst_n0, halt0, DIV0);
  always @(negedge clk) mon_step(1, tx1, bs1, ur1, rst_n1, halt1, DIV1);

  function automatic logic get_ready(input int id);
    return (id == 0) ? if0.sample_ready_o : if1.sample_ready_o;
  endfunction

  // One-cycle reset pulse; queue and model restart with it.
  task automatic do_reset(input int id, input logic [191:0] cs);
    @(posedge clk); #1;
    if (id == 0) begin
      rst_n0 = 1'b0; cs0 = cs; if0.sample_valid_i = 1'b0; q0.delete();
    end else begin
      rst_n1 = 1'b0; cs1 = cs; if1.sample_valid_i = 1'b0; q1.delete();
    end
    pops[id]  = 0;
    lvl_m[id] = 1'b0;
    frm_m[id] = 0;
    @(negedge clk);
    chk($sformatf("dut%0d ready_in_reset", id), 0, {31'd0, get_ready(id)}, 32'd0);
    @(posedge clk); #1;
    if (id == 0) rst_n0 = 1'b1;
    else         rst_n1 = 1'b1;
    #2;
    chk($sformatf("dut%0d ready_after_reset", id), 0, {31'd0, get_ready(id)}, 32'd1);
  endtask

  task automatic send_frame(input int id, input bit has, input logic [23:0] a, input logic [23:0] b,
                            input logic [1:0] v, input logic [1:0] u);
    logic [23:0] a_al, b_al;
    logic [191:0] cs;
    bit done;
    cs   = (id == 0) ? cs0 : cs1;
    a_al = has ? ((id == 0) ? a : {a[15:0], 8'h00}) : 24'h0;
    b_al = has ? ((id == 0) ? b : {b[15:0], 8'h00}) : 24'h0;
    push_frame(id, has, a_al, b_al, has ? v : 2'b11, has ? u : 2'b00, cs[frm_m[id]], frm_m[id]);
    $display("dut%0d frame %0d: %s A=%h B=%h V=%b U=%b C=%b", id, frm_m[id],
             has ? "sample" : "underrun", a_al, b_al, v, u, cs[frm_m[id]]);
    frm_m[id] = (frm_m[id] + 1) % 192;
    done = 0;
    if (has) begin
      if (id == 0) begin
        if0.sample_i = {b, a}; if0.valid_i = v; if0.user_i = u; if0.sample_valid_i = 1'b1;
      end else begin
        if1.sample_i = {b[15:0], a[15:0]}; if1.valid_i = v; if1.user_i = u; if1.sample_valid_i = 1'b1;
      end
      for (int c = 0; c < 4000 && !done; c++) begin
        @(negedge clk);
        if (get_ready(id)) done = 1;
      end
      @(posedge clk); #1;
      if (id == 0) if0.sample_valid_i = 1'b0;
      else         if1.sample_valid_i = 1'b0;
      if (!done) chk($sformatf("dut%0d handshake_timeout", id), 0, 32'd0, 32'd1);
    end else begin
      for (int c = 0; c < 4000 && !done; c++) begin
        @(negedge clk);
        if (((id == 0) ? ur0 : ur1) === 1'b1) done = 1;
      end
      @(posedge clk); #1;
      if (!done) chk($sformatf("dut%0d underrun_timeout", id), 0, 32'd0, 32'd1);
    end
  endtask

  task automatic wait_pops(input int id, input int n);
    bit done = 0;
    for (int c = 0; c < 40000 && !done; c++) begin
      @(negedge clk);
      if (pops[id] >= n) done = 1;
    end
    if (!done) chk($sformatf("dut%0d pop_timeout", id), n, 32'd0, 32'd1);
  endtask

  task automatic drain(input int id, input int div);
    bit done = 0;
    for (int c = 0; c < 40000 && !done; c++) begin
      @(negedge clk);
      if (((id == 0) ? q0.size() : q1.size()) == 0) done = 1;
    end
    if (!done) chk($sformatf("dut%0d drain_timeout", id), 0, 32'd0, 32'd1);
    repeat (div + 1) @(negedge clk);
  endtask

  task automatic chk_cap(input int id, input string name, input int first, input int len, input logic [31:0] exp);
    logic [31:0] act = '0;
    for (int k = 0; k < len; k++) act = {act[30:0], cap[id][first+k]};
    chk($sformatf("dut%0d %s", id, name), first, act, exp);
  endtask

  task automatic seq0();
    logic [191:0] cs_blk;
    do_reset(0, 192'd0);
    send_frame(0, 1, 24'h000001, 24'h000000, 2'b00, 2'b00);
    send_frame(0, 1, 24'h123456, 24'hABCDEF, 2'b10, 2'b01);
    wait_pops(0, 80);
    chk_cap(0, "preamble_z", 0, 8, 32'b11101000);
    chk_cap(0, "slots_4_6", 8, 6, 32'b101100);
    chk_cap(0, "parity_a", 62, 2, 32'b10);
    chk_cap(0, "preamble_y", 64, 8, 32'b11100100);
    send_frame(0, 0, 24'h0, 24'h0, 2'b00, 2'b00);
    send_frame(0, 0, 24'h0, 24'h0, 2'b00, 2'b00);
    send_frame(0, 1, 24'h800000, 24'h7FFFFF, 2'b01, 2'b10);
    drain(0, DIV0);

    cs_blk = '0;
    cs_blk[0]   = 1'b1;
    cs_blk[191] = 1'b1;
    do_reset(0, cs_blk);
    for (int f = 0; f < 194; f++) begin
      send_frame(0, 1, {f[7:0], 16'hC3A5}, {16'h5A0F, ~f[7:0]}, 2'b00, f[1:0]);
    end
    wait_pops(0, 193 * 128 + 80);
    do_reset(0, cs_blk);
    send_frame(0, 1, 24'h000001, 24'h000000, 2'b00, 2'b00);
    wait_pops(0, 12);
    chk_cap(0, "z_after_reset", 0, 8, 32'b11101000);
    drain(0, DIV0);
  endtask

  task automatic seq1();
    do_reset(1, 192'h2);
    send_frame(1, 1, 24'h008000, 24'h000001, 2'b00, 2'b00);
    send_frame(1, 1, 24'h001234, 24'h00FFFF, 2'b11, 2'b00);
    wait_pops(1, 72);
    chk_cap(1, "preamble_z", 0, 8, 32'b11101000);
    chk_cap(1, "slot_27_msb", 52, 6, 32'b110100);
    chk_cap(1, "parity_a", 58, 6, 32'b110010);
    wait_pops(1, 128 + 30);
    @(posedge clk); #1;
    halt1 = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    halt1 = 1'b0;
    send_frame(1, 0, 24'h0, 24'h0, 2'b00, 2'b00);
    send_frame(1, 1, 24'h00BEEF, 24'h000000, 2'b00, 2'b11);
    drain(1, DIV1);
  endtask

  initial begin
    rst_n0 = 1'b0; rst_n1 = 1'b0; halt0 = 1'b0; halt1 = 1'b0;
    cs0 = '0; cs1 = '0;
    if0.sample_i = '0; if0.sample_valid_i = 1'b0; if0.valid_i = '0; if0.user_i = '0;
    if1.sample_i = '0; if1.sample_valid_i = 1'b0; if1.valid_i = '0; if1.user_i = '0;
    for (int i = 0; i < 2; i++) begin
      lvl_m[i] = 1'b0; frm_m[i] = 0; pops[i] = 0; presc[i] = 0;
      prev_rst[i] = 1'b0; have_exp[i] = 1'b0; just_popped[i] = 1'b0;
      cur_tx[i] = 1'b0; cur_idx[i] = 0;
    end
    repeat (3) @(posedge clk);
    fork
      seq0();
      seq1();
    join
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "simulation time limit");
  end

endmodule
